// File: rtl/in_pixel_packer.sv
// Packs the input-port pixel stream into PIX-wide words for the VDMA write FIFO, tagged with sof/last/end and a pixel count.
// Optional INPORT_PACK_STAT_EN adds frame_words / drop_cnt statistics outputs.
module in_pixel_packer #(
  parameter int DSIZE = 24,
  parameter int PIX   = 4,
  localparam int WSIZE = DSIZE*PIX,
  localparam int CW    = $clog2(PIX+1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             idata_vld,
  input  logic [DSIZE-1:0] idata,
  input  logic             falign,
  input  logic             lalign,
  input  logic             ealign,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [WSIZE-1:0] fifo_wdata,
  output logic             fifo_wsof,
  output logic             fifo_wlast,
  output logic             fifo_wend,
  output logic [CW-1:0]    fifo_wnum,
  output logic             overflow,
  output logic             sync_err
`ifdef INPORT_PACK_STAT_EN
  ,
  output logic [31:0]      frame_words,
  output logic [15:0]      drop_cnt
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sof_pend, sof_pend_n;
  logic [DSIZE-1:0] slot_q [PIX];

  logic          accept, restart, emit, end_hit, sof_cur, sync_err_n;
  logic [CW-1:0] base, fill;
  logic [WSIZE-1:0] word;

  // A restart (falign) writes the current pixel at slot 0 and discards any partial word.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sof_pend_n = sof_pend;
    restart    = 1'b0;
    sync_err_n = 1'b0;
    accept     = 1'b0;
    if (idata_vld) begin
      unique case (state)
        IDLE: begin
          if (falign) begin
            restart = 1'b1;
            accept  = 1'b1;
            state_n = ACTIVE;
          end
        end
        ACTIVE: begin
          accept = 1'b1;
          if (falign) begin
            restart    = 1'b1;
            sync_err_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    base    = restart ? '0 : cnt;
    fill    = base + 1'b1;
    sof_cur = restart | sof_pend;
    end_hit = accept & ealign;
    emit    = accept & ((fill == CW'(PIX)) | lalign | ealign);

    if (accept) begin
      if (emit) begin
        cnt_n      = '0;
        sof_pend_n = 1'b0;
        if (ealign) state_n = IDLE;
      end else begin
        cnt_n      = fill;
        sof_pend_n = sof_cur;
      end
    end
  end

  // Word assembly: stored slots below base, live pixel at base, zeros above.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < PIX; i++) begin
      if (CW'(i) < base)
        word[i*DSIZE +: DSIZE] = slot_q[i];
      else if (CW'(i) == base)
        word[i*DSIZE +: DSIZE] = idata;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sof_pend <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sof_pend <= sof_pend_n;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < PIX; i++) begin
      if (accept && CW'(i) == base) slot_q[i] <= idata;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
      fifo_wsof  <= 1'b0;
      fifo_wlast <= 1'b0;
      fifo_wend  <= 1'b0;
      fifo_wnum  <= '0;
      overflow   <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      fifo_wr_en <= emit & ~fifo_full;
      sync_err   <= sync_err_n;
      if (emit && fifo_full) overflow <= 1'b1;
      if (emit && !fifo_full) begin
        fifo_wdata <= word;
        fifo_wsof  <= sof_cur;
        fifo_wlast <= lalign | ealign;
        fifo_wend  <= ealign;
        fifo_wnum  <= fill;
      end
    end
  end

`ifdef INPORT_PACK_STAT_EN
  logic        frame_done_q, restart_q;
  logic [31:0] word_acc;

  // Counting off the registered fifo_wr_en lands frame_words one cycle after the ealign word.
  always_ff @(posedge clock) begin
    if (rst) begin
      frame_done_q <= 1'b0;
      restart_q    <= 1'b0;
      word_acc     <= '0;
      frame_words  <= '0;
      drop_cnt     <= '0;
    end else begin
      frame_done_q <= end_hit;
      restart_q    <= restart;
      if (emit && fifo_full && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
      if (frame_done_q) begin
        frame_words <= (restart_q ? 32'd0 : word_acc) + 32'(fifo_wr_en);
        word_acc    <= '0;
      end else if (restart_q) begin
        word_acc <= 32'(fifo_wr_en);
      end else begin
        word_acc <= word_acc + 32'(fifo_wr_en);
      end
    end
  end
`endif

endmodule

// File: tb/tb_in_pixel_packer.sv
// Directed, table-driven bench for in_pixel_packer with DSIZE=8, PIX=4.
module tb_in_pixel_packer;

  localparam int DSIZE = 8;
  localparam int PIX   = 4;
  localparam int WSIZE = DSIZE*PIX;
  localparam int CW    = $clog2(PIX+1);

  logic             clock = 1'b0;
  logic             rst;
  logic             idata_vld;
  logic [DSIZE-1:0] idata;
  logic             falign, lalign, ealign, fifo_full;
  logic             fifo_wr_en;
  logic [WSIZE-1:0] fifo_wdata;
  logic             fifo_wsof, fifo_wlast, fifo_wend;
  logic [CW-1:0]    fifo_wnum;
  logic             overflow, sync_err;
`ifdef INPORT_PACK_STAT_EN
  logic [31:0]      frame_words;
  logic [15:0]      drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  in_pixel_packer #(.DSIZE(DSIZE), .PIX(PIX)) dut (
    .clock      (clock),
    .rst        (rst),
    .idata_vld  (idata_vld),
    .idata      (idata),
    .falign     (falign),
    .lalign     (lalign),
    .ealign     (ealign),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .fifo_wsof  (fifo_wsof),
    .fifo_wlast (fifo_wlast),
    .fifo_wend  (fifo_wend),
    .fifo_wnum  (fifo_wnum),
    .overflow   (overflow),
    .sync_err   (sync_err)
`ifdef INPORT_PACK_STAT_EN
    ,
    .frame_words(frame_words),
    .drop_cnt   (drop_cnt)
`endif
  );

  typedef struct {
    logic             vld;
    logic [DSIZE-1:0] d;
    logic             fa, la, ea, full;
    logic             wr;
    logic [WSIZE-1:0] wdata;
    logic             sof, last, wend;
    logic [CW-1:0]    num;
    logic             ovf, serr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t pix(input logic [7:0] d, input logic fa, la, ea, full, ovf, serr);
    vec_t v;
    v.vld = 1'b1; v.d = d; v.fa = fa; v.la = la; v.ea = ea; v.full = full;
    v.wr = 1'b0; v.wdata = '0; v.sof = 1'b0; v.last = 1'b0; v.wend = 1'b0; v.num = '0;
    v.ovf = ovf; v.serr = serr;
    return v;
  endfunction

  function automatic vec_t wpix(input logic [7:0] d, input logic fa, la, ea, full,
                                input logic [31:0] w, input logic sof, last, wend,
                                input int num, input logic ovf);
    vec_t v;
    v = pix(d, fa, la, ea, full, ovf, 1'b0);
    v.wr = 1'b1; v.wdata = w; v.sof = sof; v.last = last; v.wend = wend; v.num = CW'(num);
    return v;
  endfunction

  function automatic vec_t idle(input logic fa, input logic ovf);
    vec_t v;
    v = pix(8'h00, fa, 1'b0, 1'b0, 1'b0, ovf, 1'b0);
    v.vld = 1'b0;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    idata_vld = v.vld; idata = v.d; falign = v.fa; lalign = v.la; ealign = v.ea; fifo_full = v.full;
    @(posedge clock);
    #1;
    chk($sformatf("wr_en[%0d]", idx), 64'(fifo_wr_en), 64'(v.wr));
    chk($sformatf("overflow[%0d]", idx), 64'(overflow), 64'(v.ovf));
    chk($sformatf("sync_err[%0d]", idx), 64'(sync_err), 64'(v.serr));
    if (v.wr) begin
      chk($sformatf("wdata[%0d]", idx), 64'(fifo_wdata), 64'(v.wdata));
      chk($sformatf("wsof[%0d]", idx), 64'(fifo_wsof), 64'(v.sof));
      chk($sformatf("wlast[%0d]", idx), 64'(fifo_wlast), 64'(v.last));
      chk($sformatf("wend[%0d]", idx), 64'(fifo_wend), 64'(v.wend));
      chk($sformatf("wnum[%0d]", idx), 64'(fifo_wnum), 64'(v.num));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 64'(fifo_wr_en), 64'd0);
    chk({tag, "_wdata"}, 64'(fifo_wdata), 64'd0);
    chk({tag, "_flags"}, 64'({fifo_wsof, fifo_wlast, fifo_wend}), 64'd0);
    chk({tag, "_wnum"}, 64'(fifo_wnum), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_sync_err"}, 64'(sync_err), 64'd0);
`ifdef INPORT_PACK_STAT_EN
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; idata_vld = 1'b0; idata = '0;
    falign = 1'b0; lalign = 1'b0; ealign = 1'b0; fifo_full = 1'b0;

    // 2x8 frame, 1..16; an ignored falign without valid sits between words
    vecs.push_back(pix(8'h01, 1, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h02, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h03, 0, 0, 0, 0, 0, 0));
    vecs.push_back(wpix(8'h04, 0, 0, 0, 0, 32'h04030201, 1, 0, 0, 4, 0));
    vecs.push_back(idle(1, 0));
    vecs.push_back(pix(8'h05, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h06, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h07, 0, 0, 0, 0, 0, 0));
    vecs.push_back(wpix(8'h08, 0, 1, 0, 0, 32'h08070605, 0, 1, 0, 4, 0));
    vecs.push_back(pix(8'h09, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h0A, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h0B, 0, 0, 0, 0, 0, 0));
    vecs.push_back(wpix(8'h0C, 0, 0, 0, 0, 32'h0C0B0A09, 0, 0, 0, 4, 0));
    vecs.push_back(pix(8'h0D, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h0E, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h0F, 0, 0, 0, 0, 0, 0));
    vecs.push_back(wpix(8'h10, 0, 1, 1, 0, 32'h100F0E0D, 0, 1, 1, 4, 0));
    // pixels in IDLE (even with lalign/ealign) produce nothing
    vecs.push_back(pix(8'h77, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h78, 0, 1, 0, 0, 0, 0));
    vecs.push_back(pix(8'h79, 0, 1, 1, 0, 0, 0));
    // 6-pixel line -> full word + partial word, then a 4-pixel last line
    vecs.push_back(pix(8'h01, 1, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h02, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h03, 0, 0, 0, 0, 0, 0));
    vecs.push_back(wpix(8'h04, 0, 0, 0, 0, 32'h04030201, 1, 0, 0, 4, 0));
    vecs.push_back(pix(8'h05, 0, 0, 0, 0, 0, 0));
    vecs.push_back(wpix(8'h06, 0, 1, 0, 0, 32'h00000605, 0, 1, 0, 2, 0));
    vecs.push_back(pix(8'h07, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h08, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h09, 0, 0, 0, 0, 0, 0));
    vecs.push_back(wpix(8'h0A, 0, 1, 1, 0, 32'h0A090807, 0, 1, 1, 4, 0));
    // falign after 3 pixels: sync_err, partial dropped, restart
    vecs.push_back(pix(8'h21, 1, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h22, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h23, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h31, 1, 0, 0, 0, 0, 1));
    vecs.push_back(pix(8'h32, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h33, 0, 0, 0, 0, 0, 0));
    vecs.push_back(wpix(8'h34, 0, 0, 0, 0, 32'h34333231, 1, 0, 0, 4, 0));
    vecs.push_back(wpix(8'h35, 0, 1, 1, 0, 32'h00000035, 0, 1, 1, 1, 0));
    // fifo_full on a non-emit pixel is harmless; on the 2nd word it drops it
    vecs.push_back(pix(8'h41, 1, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h42, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h43, 0, 0, 0, 0, 0, 0));
    vecs.push_back(wpix(8'h44, 0, 0, 0, 0, 32'h44434241, 1, 0, 0, 4, 0));
    vecs.push_back(pix(8'h45, 0, 0, 0, 1, 0, 0));
    vecs.push_back(pix(8'h46, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h47, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pix(8'h48, 0, 0, 0, 1, 1, 0));
    vecs.push_back(pix(8'h49, 0, 0, 0, 0, 1, 0));
    vecs.push_back(pix(8'h4A, 0, 0, 0, 0, 1, 0));
    vecs.push_back(pix(8'h4B, 0, 0, 0, 0, 1, 0));
    vecs.push_back(wpix(8'h4C, 0, 1, 1, 0, 32'h4C4B4A49, 0, 1, 1, 4, 1));
    vecs.push_back(idle(0, 1));

    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

`ifdef INPORT_PACK_STAT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'd1);
    chk("frame_words", 64'(frame_words), 64'd2);
`endif

    // reset between pixels 2 and 3 of a word
    apply(pix(8'h51, 1, 0, 0, 0, 1, 0), 100);
    apply(pix(8'h52, 0, 0, 0, 0, 1, 0), 101);
    @(negedge clock);
    rst = 1'b1; idata_vld = 1'b1; idata = 8'h53; falign = 1'b0; lalign = 1'b0; ealign = 1'b0;
    @(posedge clock);
    #1;
    chk_all_zero("midrst");
    @(negedge clock);
    rst = 1'b0;
    apply(pix(8'h53, 0, 0, 0, 0, 0, 0), 102);
    apply(pix(8'h54, 0, 0, 0, 0, 0, 0), 103);
    apply(pix(8'h55, 0, 0, 0, 0, 0, 0), 104);
    apply(pix(8'h56, 0, 1, 0, 0, 0, 0), 105);
    apply(pix(8'h61, 1, 0, 0, 0, 0, 0), 106);
    apply(pix(8'h62, 0, 0, 0, 0, 0, 0), 107);
    apply(pix(8'h63, 0, 0, 0, 0, 0, 0), 108);
    apply(wpix(8'h64, 0, 0, 0, 0, 32'h64636261, 1, 0, 0, 4, 0), 109);
    apply(idle(0, 0), 110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
